// File: rtl/countmodn_pkg.sv
// Shared step-command encoding for the modulo-N counter channels.
package countmodn_pkg;

  typedef logic [1:0] cmd_t;

  // Hold and decrement are the only dedicated codes; 01 and 10 both increment.
  localparam cmd_t CMD_HOLD = 2'b00;
  localparam cmd_t CMD_INC  = 2'b01;
  localparam cmd_t CMD_DEC  = 2'b11;

endpackage : countmodn_pkg

// File: rtl/moore_countmodn_ch.sv
// One modulo-MOD up/down counter channel: state register, wrap pulse
// register and the zero-flag decode taken from the state register only.
module moore_countmodn_ch
  import countmodn_pkg::*;
#(
  parameter int MOD      = 3,
  parameter int SATURATE = 0,
  parameter int CW       = $clog2(MOD)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    data,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          q,
  output logic          wrap
);

  // Top of the count range; compared explicitly so non-power-of-two MOD works.
  localparam logic [CW-1:0] CNT_MAX = CW'(MOD - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          wrap_reg;
  logic          wrap_next;

  // Next state: a legal load beats any step, an out-of-range load just holds.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      if (load_val <= CNT_MAX) begin
        count_next = load_val;
      end
    end else begin
      case (data)
        CMD_HOLD: begin
          count_next = count_reg;
        end
        CMD_DEC: begin
          if (count_reg == '0) begin
            if (SATURATE == 0) begin
              count_next = CNT_MAX;
              wrap_next  = 1'b1;
            end
          end else begin
            count_next = count_reg - 1'b1;
          end
        end
        default: begin
          if (count_reg == CNT_MAX) begin
            if (SATURATE == 0) begin
              count_next = '0;
              wrap_next  = 1'b1;
            end
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // State and wrap registers, cleared immediately when reset goes low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;
  assign q     = (count_reg == '0);

endmodule : moore_countmodn_ch

// File: rtl/moore_countmodn_array.sv
// NUM_CH independent modulo-MOD counter channels plus an all-zero summary flag.
module moore_countmodn_array
  import countmodn_pkg::*;
#(
  parameter int MOD      = 3,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 0,
  localparam int CW      = $clog2(MOD)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2*NUM_CH-1:0]  data,
  input  logic [NUM_CH-1:0]    load,
  input  logic [CW*NUM_CH-1:0] load_val,
  output logic [CW*NUM_CH-1:0] count,
  output logic [NUM_CH-1:0]    q,
  output logic [NUM_CH-1:0]    wrap,
  output logic                 all_zero
);

  // One counter per channel; slices are packed channel 0 at the LSBs.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    moore_countmodn_ch #(
      .MOD      (MOD),
      .SATURATE (SATURATE),
      .CW       (CW)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .data     (data[2*gi +: 2]),
      .load     (load[gi]),
      .load_val (load_val[CW*gi +: CW]),
      .count    (count[CW*gi +: CW]),
      .q        (q[gi]),
      .wrap     (wrap[gi])
    );
  end

  // Zero flags come from state registers, so this stays a pure Moore output.
  assign all_zero = &q;

endmodule : moore_countmodn_array

// File: tb/tb_moore_countmodn_array.sv
module tb_moore_countmodn_array;

  // Four configurations: 0 = MOD3 wrap, 1 = MOD5 wrap, 2 = MOD5 saturate, 3 = MOD2 wrap
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]  data;
  logic [3:0]  load;
  logic [7:0]  lv3;
  logic [11:0] lv5w, lv5s;
  logic [3:0]  lv2;
  logic [7:0]  cnt3;
  logic [11:0] cnt5w, cnt5s;
  logic [3:0]  cnt2;
  logic [3:0]  q3, q5w, q5s, q2, w3, w5w, w5s, w2;
  logic        az3, az5w, az5s, az2;

  moore_countmodn_array #(.MOD(3), .NUM_CH(4), .SATURATE(0)) u_m3 (
    .clock(clock), .reset(reset), .data(data), .load(load), .load_val(lv3),
    .count(cnt3), .q(q3), .wrap(w3), .all_zero(az3));
  moore_countmodn_array #(.MOD(5), .NUM_CH(4), .SATURATE(0)) u_m5w (
    .clock(clock), .reset(reset), .data(data), .load(load), .load_val(lv5w),
    .count(cnt5w), .q(q5w), .wrap(w5w), .all_zero(az5w));
  moore_countmodn_array #(.MOD(5), .NUM_CH(4), .SATURATE(1)) u_m5s (
    .clock(clock), .reset(reset), .data(data), .load(load), .load_val(lv5s),
    .count(cnt5s), .q(q5s), .wrap(w5s), .all_zero(az5s));
  moore_countmodn_array #(.MOD(2), .NUM_CH(4), .SATURATE(0)) u_m2 (
    .clock(clock), .reset(reset), .data(data), .load(load), .load_val(lv2),
    .count(cnt2), .q(q2), .wrap(w2), .all_zero(az2));

  logic [1:0] d_cmd [4];
  logic       d_load [4];
  int         d_lv [4][4];

  int         obs_cnt [4][4];
  logic       obs_q [4][4];
  logic       obs_w [4][4];
  logic       obs_az [4];

  int         exp_cnt [4][4];
  bit         exp_w [4][4];

  int n_checks = 0;
  int n_errors = 0;

  always_comb begin
    data = '0;
    load = '0;
    lv3  = '0;
    lv5w = '0;
    lv5s = '0;
    lv2  = '0;
    for (int c = 0; c < 4; c++) begin
      data[2*c +: 2] = d_cmd[c];
      load[c]        = d_load[c];
      lv3[2*c +: 2]  = 2'(d_lv[0][c]);
      lv5w[3*c +: 3] = 3'(d_lv[1][c]);
      lv5s[3*c +: 3] = 3'(d_lv[2][c]);
      lv2[c]         = 1'(d_lv[3][c]);
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        obs_cnt[k][c] = 0;
        obs_q[k][c]   = 1'b0;
        obs_w[k][c]   = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      obs_cnt[0][c] = int'(cnt3[2*c +: 2]);
      obs_cnt[1][c] = int'(cnt5w[3*c +: 3]);
      obs_cnt[2][c] = int'(cnt5s[3*c +: 3]);
      obs_cnt[3][c] = int'(cnt2[c]);
      obs_q[0][c] = q3[c];  obs_q[1][c] = q5w[c];  obs_q[2][c] = q5s[c];  obs_q[3][c] = q2[c];
      obs_w[0][c] = w3[c];  obs_w[1][c] = w5w[c];  obs_w[2][c] = w5s[c];  obs_w[3][c] = w2[c];
    end
    obs_az[0] = az3;
    obs_az[1] = az5w;
    obs_az[2] = az5s;
    obs_az[3] = az2;
  end

  function automatic int mod_of(int k);
    return (k == 0) ? 3 : ((k == 3) ? 2 : 5);
  endfunction

  function automatic bit sat_of(int k);
    return (k == 2);
  endfunction

  function automatic int lv_max(int k);
    return (k == 0) ? 3 : ((k == 3) ? 1 : 7);
  endfunction

  // Reference: apply a signed step, then either clamp or fold back into [0, MOD).
  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        int m;
        int delta;
        int raw;
        m = mod_of(k);
        exp_w[k][c] = 1'b0;
        if (d_load[c]) begin
          if (d_lv[k][c] < m) exp_cnt[k][c] = d_lv[k][c];
        end else begin
          delta = (d_cmd[c] == 2'b00) ? 0 : ((d_cmd[c] == 2'b11) ? -1 : 1);
          raw = exp_cnt[k][c] + delta;
          if (raw < 0 || raw >= m) begin
            if (!sat_of(k)) begin
              exp_cnt[k][c] = (raw + m) % m;
              exp_w[k][c]   = 1'b1;
            end
          end else begin
            exp_cnt[k][c] = raw;
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        exp_cnt[k][c] = 0;
        exp_w[k][c]   = 1'b0;
      end
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < 4; c++) begin
      d_cmd[c]  = 2'b00;
      d_load[c] = 1'b0;
      for (int k = 0; k < 4; k++) d_lv[k][c] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    model_step();
  endtask

  // Short reset pulse between clock edges; also exercises the asynchronous clear.
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) d_cmd[c] = 2'b11;
    for (int c = 0; c < 4; c++) d_load[c] = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < 4; c++) begin
          n_checks++;
          if (obs_cnt[k][c] !== 0 || obs_q[k][c] !== 1'b1 || obs_w[k][c] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset cfg%0d ch%0d: count=%0d q=%b wrap=%b, want count=0 q=1 wrap=0",
                     k, c, obs_cnt[k][c], obs_q[k][c], obs_w[k][c]);
          end
        end
        n_checks++;
        if (obs_az[k] !== 1'b1) begin
          n_errors++;
          $display("FAIL reset_all_zero cfg%0d: all_zero=%b, want 1", k, obs_az[k]);
        end
      end
      @(posedge clock);
      #1;
    end
    // Release with decrement still applied: the first edge steps normally.
    reset = 1'b1;
    model_reset();
    cycle();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (obs_cnt[0][c] !== 2 || obs_w[0][c] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_release ch%0d: count=%0d wrap=%b, want count=2 wrap=1",
                 c, obs_cnt[0][c], obs_w[0][c]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_wrap_inc();
    int exp_seq [4] = '{1, 2, 0, 1};
    bit exp_wr [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    pulse_reset();
    idle_inputs();
    d_cmd[0] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (obs_cnt[0][0] !== exp_seq[i] || obs_w[0][0] !== exp_wr[i] ||
          obs_q[0][0] !== (exp_seq[i] == 0)) begin
        n_errors++;
        $display("FAIL wrap_inc step%0d: count=%0d wrap=%b q=%b, want count=%0d wrap=%b q=%b",
                 i, obs_cnt[0][0], obs_w[0][0], obs_q[0][0], exp_seq[i], exp_wr[i], exp_seq[i] == 0);
      end
      $display("wrap_inc step %0d count=%0d wrap=%b", i, obs_cnt[0][0], obs_w[0][0]);
    end
  endtask

  task automatic test_dec_hold();
    int exp_seq [5] = '{4, 3, 3, 3, 3};
    bit exp_wr [5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    pulse_reset();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      d_cmd[1] = (i < 2) ? 2'b11 : 2'b00;
      cycle();
      n_checks++;
      if (obs_cnt[1][1] !== exp_seq[i] || obs_w[1][1] !== exp_wr[i]) begin
        n_errors++;
        $display("FAIL dec_hold step%0d: count=%0d wrap=%b, want count=%0d wrap=%b",
                 i, obs_cnt[1][1], obs_w[1][1], exp_seq[i], exp_wr[i]);
      end
      $display("dec_hold step %0d count=%0d wrap=%b", i, obs_cnt[1][1], obs_w[1][1]);
    end
  endtask

  task automatic test_saturate();
    int exp_seq [10] = '{4, 4, 4, 4, 3, 2, 1, 0, 0, 0};
    pulse_reset();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      d_load[2]   = (i == 0);
      d_lv[2][2]  = 4;
      d_cmd[2]    = (i == 0) ? 2'b00 : ((i < 4) ? 2'b10 : 2'b11);
      cycle();
      n_checks++;
      if (obs_cnt[2][2] !== exp_seq[i] || obs_w[2][2] !== 1'b0 ||
          obs_q[2][2] !== (exp_seq[i] == 0)) begin
        n_errors++;
        $display("FAIL saturate step%0d: count=%0d wrap=%b q=%b, want count=%0d wrap=0 q=%b",
                 i, obs_cnt[2][2], obs_w[2][2], obs_q[2][2], exp_seq[i], exp_seq[i] == 0);
      end
      $display("saturate step %0d count=%0d wrap=%b", i, obs_cnt[2][2], obs_w[2][2]);
    end
  endtask

  task automatic test_load_rules();
    int lvs [3]     = '{2, 3, 0};
    int exp_seq [3] = '{2, 2, 0};
    pulse_reset();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      d_load[3]  = 1'b1;
      d_cmd[3]   = 2'b01;
      d_lv[0][3] = lvs[i];
      cycle();
      n_checks++;
      if (obs_cnt[0][3] !== exp_seq[i] || obs_w[0][3] !== 1'b0) begin
        n_errors++;
        $display("FAIL load_rules step%0d: count=%0d wrap=%b, want count=%0d wrap=0",
                 i, obs_cnt[0][3], obs_w[0][3], exp_seq[i]);
      end
      $display("load_rules step %0d load_val=%0d count=%0d", i, lvs[i], obs_cnt[0][3]);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    idle_inputs();
    // Alternating dec/inc on MOD=2 crosses the boundary on every edge.
    for (int i = 0; i < 6; i++) begin
      d_cmd[0] = (i % 2 == 0) ? 2'b11 : 2'b01;
      cycle();
      n_checks++;
      if (obs_cnt[3][0] !== ((i % 2 == 0) ? 1 : 0) || obs_w[3][0] !== 1'b1) begin
        n_errors++;
        $display("FAIL back_to_back step%0d: count=%0d wrap=%b, want count=%0d wrap=1",
                 i, obs_cnt[3][0], obs_w[3][0], (i % 2 == 0) ? 1 : 0);
      end
      $display("back_to_back step %0d count=%0d wrap=%b", i, obs_cnt[3][0], obs_w[3][0]);
    end
    // Continuous increment wraps only when leaving MOD-1.
    d_cmd[0] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (obs_cnt[3][0] !== ((i % 2 == 0) ? 1 : 0) || obs_w[3][0] !== (i % 2 == 1)) begin
        n_errors++;
        $display("FAIL inc_mod2 step%0d: count=%0d wrap=%b, want count=%0d wrap=%b",
                 i, obs_cnt[3][0], obs_w[3][0], (i % 2 == 0) ? 1 : 0, i % 2 == 1);
      end
    end
  endtask

  task automatic test_mixed();
    int e1 [4] = '{0, 1, 2, 0};
    bit w1 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    pulse_reset();
    idle_inputs();
    d_cmd[1] = 2'b01;
    d_cmd[2] = 2'b11;
    d_cmd[3] = 2'b01;
    d_load[3] = 1'b1;
    cycle();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (obs_cnt[0][c] !== e1[c] || obs_w[0][c] !== w1[c]) begin
        n_errors++;
        $display("FAIL mixed ch%0d: count=%0d wrap=%b, want count=%0d wrap=%b",
                 c, obs_cnt[0][c], obs_w[0][c], e1[c], w1[c]);
      end
    end
    n_checks++;
    if (obs_az[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL mixed_all_zero_low: all_zero=%b, want 0", obs_az[0]);
    end
    d_cmd[1] = 2'b11;
    d_cmd[2] = 2'b01;
    cycle();
    n_checks++;
    if (obs_az[0] !== 1'b1 || obs_w[0][2] !== 1'b1) begin
      n_errors++;
      $display("FAIL mixed_all_zero_high: all_zero=%b wrap2=%b, want 1 1", obs_az[0], obs_w[0][2]);
    end
    d_cmd[1] = 2'b01;
    d_load[3] = 1'b0;
    cycle();
    n_checks++;
    if (obs_az[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL mixed_all_zero_after_inc: all_zero=%b, want 0", obs_az[0]);
    end
    // Asynchronous clear between edges.
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs_cnt[0][1] !== 0 || obs_cnt[0][3] !== 0 || obs_az[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL mixed_async_reset: count1=%0d count3=%0d all_zero=%b, want 0 0 1",
               obs_cnt[0][1], obs_cnt[0][3], obs_az[0]);
    end
    reset = 1'b1;
    model_reset();
    $display("test_mixed done");
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        d_cmd[c]  = 2'($urandom_range(0, 3));
        d_load[c] = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 4; k++) d_lv[k][c] = $urandom_range(0, lv_max(k));
      end
      cycle();
      for (int k = 0; k < 4; k++) begin
        bit az;
        az = 1'b1;
        for (int c = 0; c < 4; c++) begin
          n_checks++;
          if (obs_cnt[k][c] !== exp_cnt[k][c] || obs_w[k][c] !== exp_w[k][c] ||
              obs_q[k][c] !== (exp_cnt[k][c] == 0)) begin
            n_errors++;
            $display("FAIL random n%0d cfg%0d ch%0d: count=%0d wrap=%b q=%b, want count=%0d wrap=%b q=%b",
                     n, k, c, obs_cnt[k][c], obs_w[k][c], obs_q[k][c],
                     exp_cnt[k][c], exp_w[k][c], exp_cnt[k][c] == 0);
          end
          if (exp_cnt[k][c] != 0) az = 1'b0;
        end
        n_checks++;
        if (obs_az[k] !== az) begin
          n_errors++;
          $display("FAIL random_all_zero n%0d cfg%0d: all_zero=%b, want %b", n, k, obs_az[k], az);
        end
      end
      if (n % 97 == 50) begin
        pulse_reset();
        #1;
        n_checks++;
        if (obs_cnt[1][0] !== 0 || obs_az[1] !== 1'b1 || obs_w[1][0] !== 1'b0) begin
          n_errors++;
          $display("FAIL random_async_reset n%0d: count=%0d all_zero=%b wrap=%b, want 0 1 0",
                   n, obs_cnt[1][0], obs_az[1], obs_w[1][0]);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_wrap_inc();
    test_dec_hold();
    test_saturate();
    test_load_rules();
    test_back_to_back();
    test_mixed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_moore_countmodn_array
